// File: rtl/freq_sweep_pkg.sv
// Shared types and constants for the channel-1 frequency sweep unit.
package freq_sweep_pkg;

  localparam int SWEEP_FREQ_W      = 11;
  localparam int SWEEP_ZERO_RELOAD = 8;
  localparam logic [SWEEP_FREQ_W-1:0] FREQ_MAX = 11'h7FF;

  typedef struct packed {
    logic [2:0] period;
    logic       negate;
    logic [2:0] shift;
  } nr10_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    CHECK
  } sweep_state_t;

endpackage

// File: rtl/freq_sweep_if.sv
// Sweep-unit bus: frame-sequencer/CPU controls in, frequency write-back and status out.
interface freq_sweep_if #(
  parameter int FREQ_W = 11
);
  logic              sweep_tick;
  logic              nr10_write;
  logic [6:0]        nr10_data;
  logic              trigger;
  logic [FREQ_W-1:0] freq_in;
  logic [FREQ_W-1:0] sweep_freq;
  logic              sweep_write;
  logic              channel_disable;
  logic              sweep_enabled;

  modport master (
    output sweep_tick, nr10_write, nr10_data, trigger, freq_in,
    input  sweep_freq, sweep_write, channel_disable, sweep_enabled
  );

  modport slave (
    input  sweep_tick, nr10_write, nr10_data, trigger, freq_in,
    output sweep_freq, sweep_write, channel_disable, sweep_enabled
  );
endinterface

// File: rtl/freq_sweep_calc.sv
// Combinational sweep step: shadow +/- (shadow >> shift) with add-only overflow detect.
module freq_sweep_calc #(
  parameter int FREQ_W = 11
) (
  input  logic [FREQ_W-1:0] shadow_i,
  input  logic [2:0]        shift_i,
  input  logic              negate_i,
  output logic [FREQ_W-1:0] result_o,
  output logic              overflow_o
);
  logic [FREQ_W:0] delta;
  logic [FREQ_W:0] sum;

  // NOTE: every always_comb output gets a value on every path, so no latch can form.
  always_comb begin
    delta = {1'b0, shadow_i >> shift_i};
    if (negate_i) sum = {1'b0, shadow_i} - delta;
    else          sum = {1'b0, shadow_i} + delta;
    result_o   = sum[FREQ_W-1:0];
    // Subtraction of a right-shifted copy can never go below zero.
    overflow_o = !negate_i && sum[FREQ_W];
  end
endmodule

// File: rtl/freq_sweep.sv
// Channel-1 frequency sweep: timer, shadow register and IDLE/CALC/CHECK sequencer.
module freq_sweep
  import freq_sweep_pkg::*;
#(
  parameter int FREQ_W      = SWEEP_FREQ_W,
  parameter int ZERO_RELOAD = SWEEP_ZERO_RELOAD
) (
  input  logic           clk,
  input  logic           reset,
  freq_sweep_if.slave    bus
);
  nr10_t             nr10_q;
  nr10_t             nr10_wr;
  logic [FREQ_W-1:0] shadow_q;
  logic [FREQ_W-1:0] sweep_freq_q;
  logic [3:0]        timer_q;
  logic [3:0]        reload;
  logic              enable_q;
  logic              negate_used_q;
  logic              nr10_dis_q;
  sweep_state_t      state_q;

  logic [FREQ_W-1:0] calc_result;
  logic              calc_ovf;
  logic              do_write;

  assign nr10_wr = nr10_t'(bus.nr10_data);
  assign reload  = (nr10_q.period == 3'd0) ? 4'(ZERO_RELOAD) : {1'b0, nr10_q.period};

  freq_sweep_calc #(.FREQ_W(FREQ_W)) u_calc (
    .shadow_i   (shadow_q),
    .shift_i    (nr10_q.shift),
    .negate_i   (nr10_q.negate),
    .result_o   (calc_result),
    .overflow_o (calc_ovf)
  );

  // A pending negate-mode disable wins over a write-back in the same cycle.
  assign do_write = (state_q == CALC) && !calc_ovf && (nr10_q.shift != 3'd0)
                    && !nr10_dis_q && !reset;

  assign bus.sweep_write     = do_write;
  assign bus.sweep_freq      = do_write ? calc_result : sweep_freq_q;
  assign bus.channel_disable = !reset && (nr10_dis_q || ((state_q != IDLE) && calc_ovf));
  assign bus.sweep_enabled   = enable_q;

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      nr10_q        <= '0;
      shadow_q      <= '0;
      sweep_freq_q  <= '0;
      timer_q       <= '0;
      enable_q      <= 1'b0;
      negate_used_q <= 1'b0;
      nr10_dis_q    <= 1'b0;
      state_q       <= IDLE;
    end else begin
      nr10_dis_q <= bus.nr10_write && negate_used_q && !nr10_wr.negate;
      if (bus.nr10_write) nr10_q <= nr10_wr;

      if (bus.trigger) begin
        shadow_q      <= bus.freq_in;
        timer_q       <= reload;
        negate_used_q <= 1'b0;
        enable_q      <= (nr10_q.period != 3'd0) || (nr10_q.shift != 3'd0);
        state_q       <= (nr10_q.shift != 3'd0) ? CHECK : IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.sweep_tick) begin
              if (timer_q > 4'd1) begin
                timer_q <= timer_q - 4'd1;
              end else begin
                timer_q <= reload;
                if (enable_q && (nr10_q.period != 3'd0)) state_q <= CALC;
              end
            end
          end
          CALC: begin
            if (nr10_q.negate) negate_used_q <= 1'b1;
            if (calc_ovf) begin
              state_q <= IDLE;
            end else begin
              if (do_write) begin
                shadow_q     <= calc_result;
                sweep_freq_q <= calc_result;
              end
              state_q <= CHECK;
            end
          end
          CHECK:   state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
